// File: rtl/c7bcsr_arb.sv
// Arbiter/sequencer sharing the c7bcsr access port between pipeline CSR ops and a four-phase debug requester.
// Optional macro C7BCSR_ARB_DBG_WPROT_EN drops debug writes to address >= 0x100 and flags dbg_csr_err.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | pipeline owns the port; debug request captured while waiting
// GRANT   | debug owns the port; pipeline stalled; write retried on except/ertn
// ACK     | one-cycle debug acknowledge; pipeline owns the port
// DROP    | wait for debug req to fall before accepting a new request
module c7bcsr_arb #(
  parameter int CSR_AW     = 14,
  parameter int STARVE_MAX = 15,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exu_csr_vld,
  input  logic [CSR_AW-1:0] exu_csr_raddr,
  input  logic [CSR_AW-1:0] exu_csr_waddr,
  input  logic [31:0]       exu_csr_wdata,
  input  logic [31:0]       exu_csr_mask,
  input  logic              exu_csr_wen,
  output logic [31:0]       csr_exu_rdata,
  output logic              csr_exu_stall,
  input  logic              exu_ifu_except,
  input  logic              ecl_csr_ertn_w,
  input  logic              dbg_csr_req,
  input  logic              dbg_csr_we,
  input  logic [CSR_AW-1:0] dbg_csr_addr,
  input  logic [31:0]       dbg_csr_wdata,
  input  logic [31:0]       dbg_csr_mask,
  output logic              dbg_csr_ack,
  output logic [31:0]       dbg_csr_rdata,
  output logic              dbg_csr_err,
  output logic [CSR_AW-1:0] csr_raddr,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [31:0]       csr_wdata,
  output logic [31:0]       csr_mask,
  output logic              csr_wen,
  input  logic [31:0]       csr_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ACK   = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_dbg_we;
  logic [CSR_AW-1:0]  r_dbg_addr;
  logic [31:0]        r_dbg_wdata;
  logic [31:0]        r_dbg_mask;
  logic [31:0]        r_dbg_rdata;

  logic               w_evt;
  logic               w_starved;
  logic               w_dbg_go;
  logic               w_grant_hold;
  logic               w_wprot;

  // exception/ertn commits update CSR state through their own mux legs
  assign w_evt        = exu_ifu_except | ecl_csr_ertn_w;
  assign w_starved    = (r_starve_cnt == CNT_W'(STARVE_MAX));
  assign w_dbg_go     = dbg_csr_req & (~exu_csr_vld | w_starved) & ~w_evt;
  assign w_grant_hold = r_dbg_we & w_evt;

`ifdef C7BCSR_ARB_DBG_WPROT_EN
  logic r_dbg_err;

  assign w_wprot     = r_dbg_we & (32'(r_dbg_addr) >= 32'h100);
  assign dbg_csr_err = r_dbg_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dbg_err <= 1'b0;
    end else if (r_state == S_GRANT && !w_grant_hold) begin
      r_dbg_err <= w_wprot;
    end
  end
`else
  assign w_wprot     = 1'b0;
  assign dbg_csr_err = 1'b0;
`endif

  assign csr_exu_rdata = csr_rdata;
  assign dbg_csr_rdata = r_dbg_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    csr_raddr     = exu_csr_raddr;
    csr_waddr     = exu_csr_waddr;
    csr_wdata     = exu_csr_wdata;
    csr_mask      = exu_csr_mask;
    csr_wen       = exu_csr_vld & exu_csr_wen;
    csr_exu_stall = 1'b0;
    dbg_csr_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dbg_go) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        csr_raddr     = r_dbg_addr;
        csr_waddr     = r_dbg_addr;
        csr_wdata     = r_dbg_wdata;
        csr_mask      = r_dbg_mask;
        csr_wen       = r_dbg_we & ~w_evt & ~w_wprot;
        csr_exu_stall = 1'b1;
        if (!w_grant_hold) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        dbg_csr_ack = 1'b1;
        w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (!dbg_csr_req) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // starvation counter only runs while debug waits behind a busy pipeline
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_dbg_go) begin
        r_starve_cnt <= '0;
      end else if (dbg_csr_req && exu_csr_vld && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dbg_we    <= 1'b0;
      r_dbg_addr  <= '0;
      r_dbg_wdata <= '0;
      r_dbg_mask  <= '0;
    end else if (r_state == S_IDLE && dbg_csr_req) begin
      r_dbg_we    <= dbg_csr_we;
      r_dbg_addr  <= dbg_csr_addr;
      r_dbg_wdata <= dbg_csr_wdata;
      r_dbg_mask  <= dbg_csr_mask;
    end
  end

  // read data is the pre-write value when the access is a write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dbg_rdata <= '0;
    end else if (r_state == S_GRANT && !w_grant_hold) begin
      r_dbg_rdata <= csr_rdata;
    end
  end

endmodule

// File: tb/tb_c7bcsr_arb.sv
// Self-checking bench for c7bcsr_arb: directed handshake scenarios plus a randomized phase
// checked against a shadow CSR image and transaction-level rules.
module tb_c7bcsr_arb;
  localparam int AW         = 14;
  localparam int STARVE_MAX = 15;
`ifdef C7BCSR_ARB_DBG_WPROT_EN
  localparam logic EXP_PROT = 1'b1;
`else
  localparam logic EXP_PROT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          exu_csr_vld;
  logic [AW-1:0] exu_csr_raddr, exu_csr_waddr;
  logic [31:0]   exu_csr_wdata, exu_csr_mask;
  logic          exu_csr_wen;
  logic [31:0]   csr_exu_rdata;
  logic          csr_exu_stall;
  logic          exu_ifu_except, ecl_csr_ertn_w;
  logic          dbg_csr_req, dbg_csr_we;
  logic [AW-1:0] dbg_csr_addr;
  logic [31:0]   dbg_csr_wdata, dbg_csr_mask;
  logic          dbg_csr_ack;
  logic [31:0]   dbg_csr_rdata;
  logic          dbg_csr_err;
  logic [AW-1:0] csr_raddr, csr_waddr;
  logic [31:0]   csr_wdata, csr_mask;
  logic          csr_wen;
  logic [31:0]   csr_rdata;

  logic [31:0] csr_mem [0:511] = '{default: '0};
  logic [31:0] shadow  [0:511];

  int n_vec = 0;
  int n_err = 0;
  int wen_cnt = 0, stall_cnt = 0, ack_cnt = 0;
  logic          s_ack, s_err, s_stall, s_wen;
  logic [31:0]   s_rdata;
  logic [AW-1:0] s_waddr;

  always #5 clk = ~clk;

  c7bcsr_arb #(.CSR_AW(AW), .STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .exu_csr_vld(exu_csr_vld), .exu_csr_raddr(exu_csr_raddr), .exu_csr_waddr(exu_csr_waddr),
    .exu_csr_wdata(exu_csr_wdata), .exu_csr_mask(exu_csr_mask), .exu_csr_wen(exu_csr_wen),
    .csr_exu_rdata(csr_exu_rdata), .csr_exu_stall(csr_exu_stall),
    .exu_ifu_except(exu_ifu_except), .ecl_csr_ertn_w(ecl_csr_ertn_w),
    .dbg_csr_req(dbg_csr_req), .dbg_csr_we(dbg_csr_we), .dbg_csr_addr(dbg_csr_addr),
    .dbg_csr_wdata(dbg_csr_wdata), .dbg_csr_mask(dbg_csr_mask),
    .dbg_csr_ack(dbg_csr_ack), .dbg_csr_rdata(dbg_csr_rdata), .dbg_csr_err(dbg_csr_err),
    .csr_raddr(csr_raddr), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_mask(csr_mask), .csr_wen(csr_wen), .csr_rdata(csr_rdata)
  );

  // stand-in for the c7bcsr register file
  assign csr_rdata = csr_mem[csr_raddr[8:0]];
  always @(posedge clk) begin
    if (csr_wen) csr_mem[csr_waddr[8:0]] <= (csr_mem[csr_waddr[8:0]] & ~csr_mask) | (csr_wdata & csr_mask);
  end

  function automatic logic wprot(input logic we, input logic [AW-1:0] a);
    logic r;
    r = we && (32'(a) >= 32'h100);
    if (!EXP_PROT) r = 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // one clock: sample at negedge, run the reference checks, then move to just after posedge
  task automatic tick();
    @(negedge clk);
    s_ack = dbg_csr_ack; s_err = dbg_csr_err; s_stall = csr_exu_stall;
    s_wen = csr_wen; s_rdata = dbg_csr_rdata;
    if (csr_wen) s_waddr = csr_waddr;
    wen_cnt += int'(csr_wen); stall_cnt += int'(csr_exu_stall); ack_cnt += int'(dbg_csr_ack);
    if (resetn === 1'b1) begin
      if (s_ack) begin
        chk("dbg_rdata", s_rdata, shadow[dbg_csr_addr[8:0]]);
        chk("dbg_err", 32'(s_err), 32'(wprot(dbg_csr_we, dbg_csr_addr)));
        if (dbg_csr_we && !wprot(dbg_csr_we, dbg_csr_addr))
          shadow[dbg_csr_addr[8:0]] = (shadow[dbg_csr_addr[8:0]] & ~dbg_csr_mask) | (dbg_csr_wdata & dbg_csr_mask);
      end
      if (s_stall) begin
        chk("grant_wen", 32'(s_wen),
            32'(dbg_csr_we & ~exu_ifu_except & ~ecl_csr_ertn_w & ~wprot(dbg_csr_we, dbg_csr_addr)));
        if (s_wen) begin
          chk("grant_waddr", 32'(csr_waddr), 32'(dbg_csr_addr));
          chk("grant_wdata", csr_wdata, dbg_csr_wdata);
        end
      end else begin
        chk("pipe_wen", 32'(s_wen), 32'(exu_csr_vld & exu_csr_wen));
        if (exu_csr_vld) begin
          chk("pipe_rdata", csr_exu_rdata, shadow[exu_csr_raddr[8:0]]);
          if (exu_csr_wen) begin
            chk("pipe_waddr", 32'(csr_waddr), 32'(exu_csr_waddr));
            shadow[exu_csr_waddr[8:0]] = (shadow[exu_csr_waddr[8:0]] & ~exu_csr_mask) | (exu_csr_wdata & exu_csr_mask);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // mode 0: pipeline idle, 1: random pipeline traffic, 2: back-to-back pipeline reads
  task automatic drive_pipe(input int mode);
    exu_csr_vld = 1'b0; exu_csr_wen = 1'b0; exu_ifu_except = 1'b0; ecl_csr_ertn_w = 1'b0;
    exu_csr_raddr = AW'($urandom_range(0, 31)); exu_csr_waddr = AW'($urandom_range(0, 31));
    exu_csr_wdata = $urandom; exu_csr_mask = ($urandom_range(0, 1) == 1) ? 32'hffffffff : $urandom;
    if (mode == 1) begin
      exu_csr_vld    = ($urandom_range(0, 9) < 6);
      exu_csr_wen    = ($urandom_range(0, 1) == 1);
      exu_ifu_except = ($urandom_range(0, 7) == 0);
      ecl_csr_ertn_w = ($urandom_range(0, 15) == 0);
    end else if (mode == 2) begin
      exu_csr_vld = 1'b1;
    end
  endtask

  task automatic dbg_issue(input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [31:0] m);
    dbg_csr_req = 1'b1; dbg_csr_we = we; dbg_csr_addr = a; dbg_csr_wdata = wd; dbg_csr_mask = m;
  endtask

  // returns cycles from the request cycle to the ack cycle
  task automatic wait_ack(input int mode, output int lat);
    bit got;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 300; i++) begin
      drive_pipe(mode);
      tick();
      if (s_ack) begin got = 1'b1; break; end
      lat++;
    end
    n_vec++;
    assert (got) else begin
      n_err++;
      $error("FAIL ack_timeout: observed no ack expected ack within 300 cycles");
    end
  endtask

  task automatic dbg_release(input int mode);
    drive_pipe(mode);
    dbg_csr_req = 1'b0;
    tick();
    chk("ack_one_cycle", 32'(s_ack), 32'd0);
  endtask

  initial begin
    int lat, w0, s0, a0;
    for (int i = 0; i < 512; i++) shadow[i] = '0;
    resetn = 1'b0;
    dbg_csr_req = 1'b0; dbg_csr_we = 1'b0; dbg_csr_addr = '0; dbg_csr_wdata = '0; dbg_csr_mask = '0;
    drive_pipe(0);
    #1;
    tick();
    chk("rst_ack", 32'(s_ack), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    chk("rst_stall", 32'(s_stall), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // debug read of CRMD with pipeline idle
    w0 = wen_cnt;
    dbg_issue(1'b0, AW'(0), 32'h0, 32'h0);
    wait_ack(0, lat);
    chk("crmd_latency", 32'(lat), 32'd2);
    chk("crmd_rdata", s_rdata, 32'h0);
    dbg_release(0);
    chk("crmd_no_wen", 32'(wen_cnt - w0), 32'd0);

    // debug write of EENTRY, then read it back
    w0 = wen_cnt;
    dbg_issue(1'b1, AW'('hc), 32'h1c000100, 32'hffffffff);
    wait_ack(0, lat);
    chk("eentry_wr_latency", 32'(lat), 32'd2);
    dbg_release(0);
    chk("eentry_wen_pulses", 32'(wen_cnt - w0), 32'd1);
    chk("eentry_waddr", 32'(s_waddr), 32'hc);
    dbg_issue(1'b0, AW'('hc), 32'h0, 32'h0);
    wait_ack(0, lat);
    chk("eentry_readback", s_rdata, 32'h1c000100);
    dbg_release(0);

    // write in GRANT blocked by two exception cycles
    drive_pipe(0);
    dbg_issue(1'b1, AW'('h6), 32'h0000abcd, 32'hffffffff);
    tick();
    exu_ifu_except = 1'b1;
    tick();
    chk("exc1_stall", 32'(s_stall), 32'd1);
    chk("exc1_wen", 32'(s_wen), 32'd0);
    tick();
    chk("exc2_wen", 32'(s_wen), 32'd0);
    exu_ifu_except = 1'b0;
    tick();
    chk("exc3_wen", 32'(s_wen), 32'd1);
    chk("exc3_ack", 32'(s_ack), 32'd0);
    tick();
    chk("exc_ack", 32'(s_ack), 32'd1);
    dbg_release(0);

    // COMPEN write: protected only when the write-protect option is built in
    dbg_issue(1'b1, AW'('h101), 32'h1, 32'hffffffff);
    wait_ack(0, lat);
    chk("compen_err", 32'(s_err), 32'(EXP_PROT));
    dbg_release(0);
    chk("compen_ic", 32'(csr_mem[9'h101][0]), 32'(!EXP_PROT));

    // req held past ack: one access, one ack, no re-grant until req falls
    a0 = ack_cnt; s0 = stall_cnt;
    dbg_issue(1'b0, AW'('hc), 32'h0, 32'h0);
    wait_ack(0, lat);
    for (int i = 0; i < 5; i++) begin drive_pipe(0); tick(); end
    chk("hold_acks", 32'(ack_cnt - a0), 32'd1);
    chk("hold_grants", 32'(stall_cnt - s0), 32'd1);
    dbg_release(0);
    dbg_issue(1'b0, AW'('h0), 32'h0, 32'h0);
    wait_ack(0, lat);
    chk("hold_back_to_idle", 32'(lat), 32'd2);
    dbg_release(0);

    // starvation: pipeline busy every cycle
    s0 = stall_cnt;
    dbg_issue(1'b0, AW'('h6), 32'h0, 32'h0);
    wait_ack(2, lat);
    chk("starve_latency", 32'(lat), 32'(STARVE_MAX + 2));
    chk("starve_stall_cycles", 32'(stall_cnt - s0), 32'd1);
    dbg_release(2);
    for (int i = 0; i < 3; i++) begin drive_pipe(2); tick(); end

    // reset asserted while a debug write sits in GRANT
    drive_pipe(0);
    dbg_issue(1'b1, AW'('h5), 32'hdeadbeef, 32'hffffffff);
    tick();
    resetn = 1'b0; dbg_csr_req = 1'b0;
    tick();
    chk("rstgrant_wen", 32'(s_wen), 32'd0);
    chk("rstgrant_stall", 32'(s_stall), 32'd0);
    tick();
    resetn = 1'b1;
    tick(); tick();
    chk("rstgrant_mem", csr_mem[5], shadow[5]);

    // randomized accesses under random pipeline traffic
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'('h101) : AW'($urandom_range(0, 31));
      dbg_issue($urandom_range(0, 1) == 1, a, $urandom,
                ($urandom_range(0, 1) == 1) ? 32'hffffffff : $urandom);
      wait_ack(1, lat);
      dbg_release(1);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin drive_pipe(1); tick(); end
    end
    drive_pipe(0);
    tick(); tick();
    for (int i = 0; i < 32; i++) chk("final_mem", csr_mem[i], shadow[i]);
    chk("final_mem_101", csr_mem[9'h101], shadow[9'h101]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
